// File: rtl/qh_pkg.sv
// Shared constants, state encoding and error-flag positions for the
// quickhull job controller and its point buffers.
package qh_pkg;

  localparam int PT_W    = 16;
  localparam int MAX_PTS = 256;
  localparam int CNT_W   = 9;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int ERR_LOAD_OVF = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_HULL_OVF = 2;

endpackage

// File: rtl/qh_point_ram.sv
// Simple dual-port point RAM with one write port and a registered read port.
// Used for both the input point buffer and the hull buffer.
module qh_point_ram #(
  parameter int DATA_W = qh_pkg::PT_W,
  parameter int DEPTH  = qh_pkg::MAX_PTS,
  parameter int ADDR_W = qh_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/quickhull_job_controller.sv
// Job controller for a quickhull processor: buffers an input point set, starts
// the processor, collects its hull points and streams them back out.
module quickhull_job_controller #(
  parameter int MAX_PTS = qh_pkg::MAX_PTS,
  parameter int PT_W    = qh_pkg::PT_W,
  parameter int TIMEOUT = 65535
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [PT_W-1:0] in_point,
  output logic            qh_start,
  output logic [8:0]      qh_size,
  input  logic [7:0]      qh_rd_addr,
  output logic [PT_W-1:0] qh_rd_data,
  input  logic            qh_hull_valid,
  input  logic [PT_W-1:0] qh_hull_point,
  input  logic            qh_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [PT_W-1:0] out_point,
  output logic [8:0]      hull_size,
  output logic            busy,
  output logic [2:0]      err
);
  import qh_pkg::*;

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_hull_wr_ptr;
  logic [CNT_W-1:0]  r_hull_size;
  logic [TMO_W-1:0]  r_tmo;
  logic [2:0]        r_err;
  logic              r_qh_start;
  logic              r_out_valid;
  logic              r_out_last;
  logic [ADDR_W-1:0] r_out_idx;

  logic              w_in_fire;
  logic              w_load_full;
  logic              w_pt_we;
  logic [ADDR_W-1:0] w_pt_addr;
  logic              w_hull_fire;
  logic              w_hull_full;
  logic              w_hull_acc;
  logic              w_hull_we;
  logic [ADDR_W-1:0] w_hull_wr_addr;
  logic [PT_W-1:0]   w_hull_wr_data;
  logic [ADDR_W-1:0] w_hull_rd_addr;
  logic              w_out_fire;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_ptr_next;

  // Assertion is immediate; release is delayed by two clock edges.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign in_ready    = w_rst_n && (r_state == ST_IDLE || r_state == ST_LOAD);
  assign w_in_fire   = in_valid && in_ready;
  assign w_load_full = (r_state == ST_LOAD) && (r_cnt == CNT_W'(MAX_PTS));
  assign w_pt_we     = w_in_fire && !w_load_full;
  assign w_pt_addr   = (r_state == ST_IDLE) ? '0 : r_cnt[ADDR_W-1:0];
  assign w_cnt_next  = r_cnt + CNT_W'(1);

  assign w_hull_fire = (r_state == ST_RUN) && qh_hull_valid;
  assign w_hull_full = (r_hull_wr_ptr == r_cnt);
  assign w_hull_acc  = w_hull_fire && !w_hull_full;
  assign w_ptr_next  = r_hull_wr_ptr + CNT_W'(w_hull_acc);

  // The first two loaded points are mirrored into the hull buffer so that a
  // job too small for the processor can be drained without a copy phase.
  assign w_hull_we      = w_hull_acc || (w_pt_we && (w_pt_addr[ADDR_W-1:1] == '0));
  assign w_hull_wr_addr = (r_state == ST_RUN) ? r_hull_wr_ptr[ADDR_W-1:0] : w_pt_addr;
  assign w_hull_wr_data = (r_state == ST_RUN) ? qh_hull_point : in_point;

  assign w_out_fire     = r_out_valid && out_ready;
  assign w_hull_rd_addr = (w_out_fire && !r_out_last) ? r_out_idx + 1'b1 : r_out_idx;

  qh_point_ram #(.DATA_W(PT_W), .DEPTH(MAX_PTS), .ADDR_W(ADDR_W)) u_pt_ram (
    .clk       (CLK100MHZ),
    .i_we      (w_pt_we),
    .i_wr_addr (w_pt_addr),
    .i_wr_data (in_point),
    .i_rd_addr (qh_rd_addr),
    .o_rd_data (qh_rd_data)
  );

  qh_point_ram #(.DATA_W(PT_W), .DEPTH(MAX_PTS), .ADDR_W(ADDR_W)) u_hull_ram (
    .clk       (CLK100MHZ),
    .i_we      (w_hull_we),
    .i_wr_addr (w_hull_wr_addr),
    .i_wr_data (w_hull_wr_data),
    .i_rd_addr (w_hull_rd_addr),
    .o_rd_data (out_point)
  );

  always_ff @(posedge CLK100MHZ or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_hull_wr_ptr <= '0;
      r_hull_size   <= '0;
      r_tmo         <= '0;
      r_err         <= '0;
      r_qh_start    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_idx     <= '0;
    end else begin
      r_qh_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_err <= '0;
            r_cnt <= CNT_W'(1);
            if (in_last) begin
              r_hull_size <= CNT_W'(1);
              r_state     <= ST_DRAIN;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_in_fire) begin
            if (w_load_full) begin
              r_err[ERR_LOAD_OVF] <= 1'b1;
              r_qh_start          <= 1'b1;
              r_state             <= ST_START;
            end else begin
              r_cnt <= w_cnt_next;
              if (in_last) begin
                if (w_cnt_next < CNT_W'(3)) begin
                  r_hull_size <= w_cnt_next;
                  r_state     <= ST_DRAIN;
                end else begin
                  r_qh_start <= 1'b1;
                  r_state    <= ST_START;
                end
              end
            end
          end
        end
        ST_START: begin
          r_hull_wr_ptr <= '0;
          r_tmo         <= '0;
          r_state       <= ST_RUN;
        end
        ST_RUN: begin
          if (w_hull_fire && w_hull_full) r_err[ERR_HULL_OVF] <= 1'b1;
          r_hull_wr_ptr <= w_ptr_next;
          r_tmo         <= r_tmo + 1'b1;
          if (qh_done || r_tmo == TMO_LAST) begin
            if (!qh_done) r_err[ERR_TIMEOUT] <= 1'b1;
            r_hull_size <= w_ptr_next;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The first DRAIN cycle only primes the registered hull read of entry 0.
          if (!r_out_valid) begin
            if (r_hull_size == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_out_valid <= 1'b1;
              r_out_last  <= (r_hull_size == CNT_W'(1));
            end
          end else if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_idx   <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_out_idx  <= r_out_idx + 1'b1;
              r_out_last <= (({1'b0, r_out_idx} + CNT_W'(2)) == r_hull_size);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign qh_start  = r_qh_start;
  assign qh_size   = r_cnt;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign hull_size = r_hull_size;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

endmodule

// File: doc/quickhull_job_controller.md
QUICKHULL_JOB_CONTROLLER -- requirements
Module: quickhull_job_controller

Interface
REQ-001 The block SHALL have parameter MAX_PTS, default 256: maximum number of points per job.
REQ-002 The block SHALL have parameter PT_W, default 16: point width, {x[15:8], y[7:0]}.
REQ-003 The block SHALL have parameter TIMEOUT, default 65535: RUN-state cycle limit.
REQ-004 CLK100MHZ  in  1  sole clock, rising edge.
REQ-005 CPU_RESETN  in  1  reset, asynchronous, active-low.
REQ-006 in_valid / in_ready / in_last  in / out / in  1 each  point-load handshake.
REQ-007 in_point  in  PT_W  point being loaded.
REQ-008 qh_start  out  1  one-cycle job start pulse to the hull processor.
REQ-009 qh_size  out  9  point count of the current job, 1..256.
REQ-010 qh_rd_addr  in  8  processor read address into the point buffer.
REQ-011 qh_rd_data  out  PT_W  point at qh_rd_addr, one-cycle read latency.
REQ-012 qh_hull_valid / qh_hull_point  in  1 / PT_W  hull point write from the processor.
REQ-013 qh_done  in  1  single-cycle job-complete pulse.
REQ-014 out_valid / out_ready / out_last  out / in / out  1 each  hull output handshake.
REQ-015 out_point  out  PT_W  hull point being output.
REQ-016 hull_size  out  9  hull point count of the last completed job.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 err  out  3  sticky flags: [0] load overflow, [1] timeout, [2] hull overflow.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, START, RUN, DRAIN.
REQ-020 in_ready SHALL be high only in IDLE and LOAD; a transfer occurs when in_valid and in_ready are both high.
REQ-021 In IDLE, a transfer SHALL write address 0, set cnt=1 and go to LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-022 In LOAD, each transfer SHALL write address cnt and then increment cnt.
REQ-023 A transfer with in_last=1 SHALL move the FSM to START on the next edge.
REQ-024 When cnt=MAX_PTS, a further transfer SHALL be dropped, SHALL set err[0], and SHALL be treated as in_last.
REQ-025 If cnt<3 when in_last is accepted, the FSM SHALL bypass the processor: copy the points into the hull buffer in order, set hull_size=cnt and go to DRAIN.
REQ-026 In START, qh_start SHALL be high for exactly one cycle, qh_size SHALL equal cnt, and the FSM SHALL then enter RUN.
REQ-027 In RUN, qh_rd_data SHALL return the point buffer word at qh_rd_addr one cycle later.
REQ-028 In RUN, each qh_hull_valid SHALL write qh_hull_point at hull_wr_ptr and increment hull_wr_ptr.
REQ-029 A hull write when hull_wr_ptr=cnt SHALL be dropped and SHALL set err[2].
REQ-030 On qh_done, the FSM SHALL latch hull_size=hull_wr_ptr (including a same-cycle hull write) and go to DRAIN.
REQ-031 If qh_done and qh_hull_valid occur in the same cycle, the write SHALL be counted.
REQ-032 A RUN cycle counter SHALL set err[1] at TIMEOUT cycles and force DRAIN with the current hull_wr_ptr.
REQ-033 In DRAIN, out_valid SHALL assert at most one cycle after entry and present hull entries 0..hull_size-1 in order.
REQ-034 out_point SHALL hold stable while out_valid is high and out_ready is low.
REQ-035 out_last SHALL be high on entry hull_size-1.
REQ-036 hull_size=0 in DRAIN SHALL return to IDLE without asserting out_valid.
REQ-037 The handshake with out_last high SHALL return the FSM to IDLE.
REQ-038 err bits SHALL clear only on reset or on the first accepted load of a new job.

Reset
REQ-039 Asserting CPU_RESETN low SHALL immediately force state IDLE, cnt=0, hull_wr_ptr=0, hull_size=0, err=0, and in_ready, qh_start, out_valid, out_last, busy all 0.
REQ-040 Reset SHALL NOT clear buffer RAM contents.
REQ-041 Reset in any state SHALL abort the job; the first transfer after release SHALL start a new job at address 0.
REQ-042 Reset deassertion SHALL be synchronised internally with a two-flop release.

Structure
REQ-043 Package qh_pkg SHALL hold PT_W, MAX_PTS, CNT_W=9, the state enum, and the err bit indices.
REQ-044 The two 256xPT_W simple dual-port RAMs (point buffer and hull buffer) SHALL be instances of one sub-module, qh_point_ram, with registered read.

Verification
REQ-045 Load 15 points (last on the 15th); processor model writes 6 hull points, then qh_done -> qh_start pulse with qh_size=15; out emits 6 points in write order; out_last on the 6th; hull_size=6.
REQ-046 Load 256 points, then send a 257th with in_last -> err[0]=1; qh_size=256; the 257th point is absent from the buffer.
REQ-047 Load 2 points -> no qh_start; out emits both input points; hull_size=2.
REQ-048 Processor model never asserts qh_done -> err[1]=1 after 65535 RUN cycles; partial hull drained.
REQ-049 Hold out_ready low for 10 cycles mid-DRAIN -> out_point stable and no point lost or duplicated.
REQ-050 Pulse CPU_RESETN low during RUN -> outputs reset immediately; a new 3-point job completes normally.
